// File: rtl/psum_drain.sv
// Column drain for a systolic array: resolves carry-save partial sums, accumulates tiles
// per output element, requantises to saturated int8 and buffers results in a small FIFO.
module psum_drain #(
    parameter int SIZE  = 4,
    parameter int BUSW  = $clog2(SIZE) + 16,
    parameter int DEPTH = 4,
    parameter int SHIFT = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [BUSW-1:0] psum0,
    input  logic signed [BUSW-1:0] psum1,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [7:0]      out_data,
    output logic                   sat_flag
);

    localparam int ACCW = BUSW + 4;
    localparam int PW   = $clog2(DEPTH);
    localparam int OW   = PW + 2;

    localparam logic signed [ACCW-1:0] SAT_HI = ACCW'(127);
    localparam logic signed [ACCW-1:0] SAT_LO = ACCW'(-128);
    localparam logic [OW-1:0]          OCC_MAX = OW'(DEPTH);

    logic                   accept;

    // Stage 1: carry-save resolution
    logic                   s1_valid;
    logic                   s1_last;
    logic signed [BUSW-1:0] s1_sum;

    // Stage 2: accumulation and requantisation
    logic signed [ACCW-1:0] acc;
    logic signed [ACCW-1:0] total;
    logic signed [ACCW-1:0] shifted;
    logic signed [7:0]      sat_val;
    logic                   clip;
    logic                   s2_push;
    logic signed [7:0]      s2_data;

    // Output FIFO
    logic signed [7:0]      mem [DEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [PW:0]            count;
    logic                   pop;
    logic [OW-1:0]          occ;

    // Every last beat already past the input counts against FIFO space, so a
    // full FIFO plus a full pipeline can never overflow.
    assign occ      = OW'(count) + OW'(s1_valid && s1_last) + OW'(s2_push);
    assign in_ready = (occ < OCC_MAX);
    assign accept   = in_valid && in_ready;

    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign pop       = out_valid && out_ready;

    // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
    always_comb begin
        total   = acc + {{(ACCW-BUSW){s1_sum[BUSW-1]}}, s1_sum};
        shifted = total >>> SHIFT;
        clip    = 1'b0;
        sat_val = shifted[7:0];
        if (shifted > SAT_HI) begin
            sat_val = 8'sd127;
            clip    = 1'b1;
        end else if (shifted < SAT_LO) begin
            sat_val = -8'sd128;
            clip    = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_sum   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_sum  <= psum0 + psum1;
                s1_last <= in_last;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            s2_push  <= 1'b0;
            s2_data  <= '0;
            sat_flag <= 1'b0;
        end else begin
            s2_push <= 1'b0;
            if (s1_valid) begin
                if (s1_last) begin
                    s2_push <= 1'b1;
                    s2_data <= sat_val;
                    acc     <= '0;
                    if (clip) begin
                        sat_flag <= 1'b1;
                    end
                end else begin
                    acc <= total;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (s2_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({s2_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; out_valid gates it, so stale contents are never seen.
    always_ff @(posedge clk) begin
        if (s2_push) begin
            mem[wr_ptr] <= s2_data;
        end
    end

endmodule

// File: tb/tb_psum_drain.sv
// Directed bench for psum_drain: reset, latency, saturation, carry-save wrap,
// backpressure ordering and reset mid-element, with a second instance at SHIFT=2.
module tb_psum_drain;

    localparam int BUSW = 18;

    logic                   clk;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_last;
    logic                   out_ready;
    logic signed [BUSW-1:0] psum0;
    logic signed [BUSW-1:0] psum1;

    logic                   in_ready;
    logic                   out_valid;
    logic signed [7:0]      out_data;
    logic                   sat_flag;
    logic                   in_ready2;
    logic                   out_valid2;
    logic signed [7:0]      out_data2;
    logic                   sat_flag2;

    int total;
    int bad;

    psum_drain #(.SIZE(4), .BUSW(BUSW), .DEPTH(4), .SHIFT(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .psum0(psum0), .psum1(psum1), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .sat_flag(sat_flag)
    );

    psum_drain #(.SIZE(4), .BUSW(BUSW), .DEPTH(4), .SHIFT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .psum0(psum0), .psum1(psum1), .in_last(in_last),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .sat_flag(sat_flag2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All tasks enter and leave just after a falling edge.
    task automatic send_beat(input int p0, input int p1, input bit last, output bit ok);
        ok       = 1'b0;
        in_valid = 1'b1;
        psum0    = BUSW'(p0);
        psum1    = BUSW'(p1);
        in_last  = last;
        for (int i = 0; i < 8; i++) begin
            if (in_ready) begin
                @(negedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_out(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        total++;
        if (out_valid !== 1'b0 || out_data !== 8'sd0 || in_ready !== 1'b1 || sat_flag !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: valid=%b data=%0d ready=%b sat=%b required 0 0 1 0",
                     out_valid, out_data, in_ready, sat_flag);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL post_reset: valid=%b ready=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_single();
        bit ok;
        send_beat(100, -30, 1'b1, ok);
        in_valid = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL single_accept: accepted=%b required 1", ok);
        end
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_lat1: out_valid=%b required 0", out_valid);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_lat2: out_valid=%b required 0", out_valid);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || int'(out_data) !== 70 || sat_flag !== 1'b0) begin
            bad++;
            $display("FAIL single_value: valid=%b data=%0d sat=%b required 1 70 0",
                     out_valid, out_data, sat_flag);
        end
        pop_one();
    endtask

    task automatic test_saturate();
        bit ok;
        bit all_ok;
        all_ok = 1'b1;
        send_beat(50, 0, 1'b0, ok);  all_ok &= ok;
        send_beat(40, 0, 1'b0, ok);  all_ok &= ok;
        send_beat(30, 10, 1'b1, ok); all_ok &= ok;
        in_valid = 1'b0;
        wait_out(ok);
        total++;
        if (!all_ok || !ok || int'(out_data) !== 127 || sat_flag !== 1'b1) begin
            bad++;
            $display("FAIL sat_high: ok=%b data=%0d sat=%b required 127 1", all_ok && ok, out_data, sat_flag);
        end
        pop_one();
        send_beat(-200, 0, 1'b1, ok);
        in_valid = 1'b0;
        wait_out(ok);
        total++;
        if (!ok || int'(out_data) !== -128) begin
            bad++;
            $display("FAIL sat_low: ok=%b data=%0d required -128", ok, out_data);
        end
        pop_one();
    endtask

    task automatic test_async_reset();
        bit ok;
        send_beat(3, 0, 1'b1, ok);
        in_valid = 1'b0;
        wait_out(ok);
        send_beat(7, 0, 1'b0, ok);
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || sat_flag !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset: valid=%b sat=%b required 1 1", out_valid, sat_flag);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_data !== 8'sd0 || in_ready !== 1'b1 || sat_flag !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: valid=%b data=%0d ready=%b sat=%b required 0 0 1 0",
                     out_valid, out_data, in_ready, sat_flag);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_no_output: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        send_beat(131071, 1, 1'b1, ok);
        in_valid = 1'b0;
        wait_out(ok);
        total++;
        if (!ok || int'(out_data) !== -128) begin
            bad++;
            $display("FAIL cs_wrap: ok=%b data=%0d required -128", ok, out_data);
        end
        pop_one();
    endtask

    task automatic test_backpressure();
        bit ok;
        int accepted;
        int got_n;
        int got [8];
        accepted  = 0;
        out_ready = 1'b0;
        for (int v = 1; v <= 6; v++) begin
            send_beat(v, 0, 1'b1, ok);
            if (!ok) break;
            accepted++;
        end
        total++;
        if (accepted !== 4 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_stall: accepted=%0d ready=%b required 4 0", accepted, in_ready);
        end
        total++;
        if (out_valid !== 1'b1 || int'(out_data) !== 1) begin
            bad++;
            $display("FAIL bp_hold: valid=%b data=%0d required 1 1", out_valid, out_data);
        end
        in_valid = 1'b0;
        got_n = 0;
        fork
            begin
                bit dok;
                for (int v = 5; v <= 6; v++) begin
                    send_beat(v, 0, 1'b1, dok);
                end
                in_valid = 1'b0;
            end
            begin
                out_ready = 1'b1;
                for (int c = 0; c < 40 && got_n < 6; c++) begin
                    if (out_valid) begin
                        got[got_n] = int'(out_data);
                        got_n++;
                    end
                    @(negedge clk);
                end
                out_ready = 1'b0;
            end
        join
        total++;
        if (got_n !== 6) begin
            bad++;
            $display("FAIL bp_count: got=%0d required 6", got_n);
        end
        for (int i = 0; i < got_n; i++) begin
            total++;
            if (got[i] !== i + 1) begin
                bad++;
                $display("FAIL bp_order[%0d]: got=%0d required %0d", i, got[i], i + 1);
            end
        end
        repeat (4) @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_extra: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_element();
        bit ok;
        send_beat(7, 0, 1'b0, ok);
        send_beat(8, 0, 1'b0, ok);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send_beat(5, 0, 1'b1, ok);
        in_valid = 1'b0;
        wait_out(ok);
        total++;
        if (!ok || int'(out_data) !== 5 || int'(out_data2) !== 1) begin
            bad++;
            $display("FAIL mid_reset: ok=%b data=%0d data2=%0d required 5 1", ok, out_data, out_data2);
        end
        pop_one();
        send_beat(-9, 0, 1'b1, ok);
        in_valid = 1'b0;
        wait_out(ok);
        total++;
        if (!ok || int'(out_data) !== -9 || int'(out_data2) !== -3) begin
            bad++;
            $display("FAIL shift_floor: ok=%b data=%0d data2=%0d required -9 -3", ok, out_data, out_data2);
        end
        pop_one();
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        psum0     = '0;
        psum1     = '0;
        test_reset();
        test_single();
        test_saturate();
        test_async_reset();
        test_wrap();
        test_backpressure();
        test_reset_mid_element();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/psum_drain.md
PSUM_DRAIN -- requirements
Module: psum_drain

Interface
REQ-001 SHALL have parameter SIZE, default 4: array dimension, i.e. PEs per column.
REQ-002 SHALL have parameter BUSW, default ceillog2(SIZE)+16: width of each carry-save psum word.
REQ-003 SHALL have parameter DEPTH, default 4: output FIFO entries (power of two, >=2).
REQ-004 SHALL have parameter SHIFT, default 0: arithmetic right-shift applied before int8 saturation.
REQ-005 SHALL use an internal accumulator of width ACCW = BUSW+4.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 in_valid  input  1  carry-save pair present on psum0/psum1.
REQ-009 in_ready  output  1  block accepts the pair this cycle.
REQ-010 psum0  input  BUSW  carry-save word 0 from the bottom PE, signed.
REQ-011 psum1  input  BUSW  carry-save word 1 from the bottom PE, signed.
REQ-012 in_last  input  1  beat is the final tile of the current output element.
REQ-013 out_valid  output  1  out_data holds a valid element.
REQ-014 out_ready  input  1  consumer takes out_data this cycle.
REQ-015 out_data  output  8  signed int8 result.
REQ-016 sat_flag  output  1  sticky flag: some result was clipped.

Function
REQ-017 SHALL accept a beat only when in_valid && in_ready; beats received with in_ready=0 are ignored.
REQ-018 Stage 1 SHALL register sum = (psum0+psum1) mod 2^BUSW, with the carry-out discarded and the result read as signed BUSW.
REQ-019 Stage 2 SHALL sign-extend sum to ACCW and add it to acc; on a non-last beat the result is stored in acc.
REQ-020 On a last beat, stage 2 SHALL compute r = (acc+sum) >>> SHIFT, saturate r to [-128,127], push the result to the FIFO and clear acc to 0 in the same cycle.
REQ-021 If saturation clips r, sat_flag SHALL set; it clears only on reset.
REQ-022 Latency SHALL be 2 cycles: a last beat accepted at edge t gives out_valid=1 after edge t+2 when the FIFO was empty.
REQ-023 Occupancy SHALL equal FIFO entries plus last-beats in flight in stages 1-2.
REQ-024 in_ready SHALL be 1 iff occupancy < DEPTH, so no last beat is ever dropped.
REQ-025 in_ready SHALL be purely registered-state derived, with no combinational path from in_valid or out_ready.
REQ-026 A FIFO pop SHALL occur when out_valid && out_ready.
REQ-027 Simultaneous push and pop SHALL leave the count unchanged; a push into a full FIFO cannot occur (REQ-024).
REQ-028 FIFO pointers SHALL wrap modulo DEPTH, and output order SHALL equal completion order.
REQ-029 out_data SHALL show the FIFO head and SHALL hold stable while out_valid && !out_ready.
REQ-030 Accumulation across beats SHALL be unbounded by count; ACCW overflow wraps silently and is out of spec.

Reset
REQ-031 rst_n=0 SHALL immediately clear acc, the pipeline valid bits, FIFO pointers and count, and sat_flag.
REQ-032 During reset, out_valid=0, out_data=0 and in_ready=1.
REQ-033 Reset mid-accumulation SHALL discard the partial sum with no output.
REQ-034 After rst_n rises, the first beat SHALL be treated as a fresh element.

Verification
REQ-035 Reset: rst_n low mid-run -> out_valid=0, out_data=0, in_ready=1 and sat_flag=0 asynchronously.
REQ-036 Single last beat psum0=100, psum1=-30, SHIFT=0 -> out_data=70, out_valid=1 two cycles after acceptance.
REQ-037 Beats (50,0), (40,0), (30,10,last) -> out_data=127 and sat_flag=1; then a beat (-200,0,last) -> out_data=-128.
REQ-038 Carry-save wrap at BUSW=18: psum0=0x1FFFF, psum1=1, last -> sum=-131072 -> out_data=-128.
REQ-039 Backpressure: out_ready=0 with 6 consecutive last beats (values 1..6) -> in_ready=0 once occupancy=4; after out_ready=1, outputs 1,2,3,4,5,6 in order, none lost or duplicated.
REQ-040 Reset mid-element: beats (7,0), (8,0) non-last, pulse rst_n, then (5,0,last) -> out_data=5; with SHIFT=2 run separately, (-9,0,last) -> -3 (floor).
